spi_dac_word_receiver: RTL and testbench

- SPI slave receiver: the far end of the diodController SPI master link (spi_ss, spi_clk, spi_mosi).
- Oversamples the three SPI lines in the system clock domain and deserialises DATA_WIDTH-bit words, MSB first, SPI mode 0.
- Presents each word with a one-cycle valid strobe and holds the last good word as the DAC voltage value.
- Used as the DAC-side model in the controller's closed-loop bench, and as a loopback checker on the board.

---
 rtl/spi_dac_word_receiver_if.sv | 19 +
 rtl/spi_dac_word_receiver.sv | 167 ++++++++++++++++
 tb/tb_spi_dac_word_receiver.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_dac_word_receiver_if.sv
// SPI link between the diodController master and the DAC-side word receiver.
// The master drives all three lines; the receiver only observes them.
interface spi_dac_word_receiver_if;
    logic spi_ss;
    logic spi_clk;
    logic spi_mosi;

    modport master (
        output spi_ss,
        output spi_clk,
        output spi_mosi
    );

    modport slave (
        input spi_ss,
        input spi_clk,
        input spi_mosi
    );
endinterface

// File: rtl/spi_dac_word_receiver.sv
// SPI mode-0 slave that oversamples the link in the clk domain and deserialises MSB-first words.
// Good frames update the DAC voltage word; short or long frames only flag an error.
module spi_dac_word_receiver #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    spi_dac_word_receiver_if.slave spi,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_error,
    output logic [DATA_WIDTH-1:0] dac_voltage,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic                  busy
);

    localparam int BW = $clog2(DATA_WIDTH + 2);
    localparam logic [BW-1:0] BITS_FULL = BW'(DATA_WIDTH);
    localparam logic [BW-1:0] BITS_OVER = BW'(DATA_WIDTH + 1);
    localparam int SW = $clog2(SYNC_STAGES + 2);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        END       = 2'd3
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] ss_pipe, clk_pipe, mosi_pipe;
    logic                   ss_prev, clk_prev;
    logic                   ss_s, clk_s, mosi_s;
    logic                   ss_rise, ss_fall, clk_rise;
    logic [SW-1:0]          settle_cnt;
    logic                   settled;
    logic [DATA_WIDTH-1:0]  shift_reg;
    logic [BW-1:0]          bit_cnt;
    logic                   start_frame, take_bit, finish_good, finish_bad;

    assign ss_s     = ss_pipe[SYNC_STAGES-1];
    assign clk_s    = clk_pipe[SYNC_STAGES-1];
    assign mosi_s   = mosi_pipe[SYNC_STAGES-1];
    assign ss_rise  = ss_s & ~ss_prev;
    assign ss_fall  = ~ss_s & ss_prev;
    assign clk_rise = clk_s & ~clk_prev;
    assign settled  = (settle_cnt == SETTLE_MAX);
    assign busy     = (state == SHIFT);

    // Synchronisers plus one history flop per line; ss idles high so its chain resets to 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ss_pipe   <= '1;
            clk_pipe  <= '0;
            mosi_pipe <= '0;
            ss_prev   <= 1'b1;
            clk_prev  <= 1'b0;
        end else begin
            ss_pipe   <= {ss_pipe[SYNC_STAGES-2:0], spi.spi_ss};
            clk_pipe  <= {clk_pipe[SYNC_STAGES-2:0], spi.spi_clk};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], spi.spi_mosi};
            ss_prev   <= ss_s;
            clk_prev  <= clk_s;
        end
    end

    // The ss chain resets to "inactive", so a pin held low through reset only becomes
    // visible after the chain flushes; WAIT_IDLE must not trust ss until then.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            settle_cnt <= '0;
        end else if (!settled) begin
            settle_cnt <= settle_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= WAIT_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        take_bit    = 1'b0;
        finish_good = 1'b0;
        finish_bad  = 1'b0;
        case (state)
            WAIT_IDLE: begin
                if (settled && ss_s && ss_prev) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (ss_fall) begin
                    start_frame = 1'b1;
                    state_next  = SHIFT;
                end
            end
            SHIFT: begin
                take_bit = clk_rise;
                if (ss_rise) begin
                    state_next = END;
                end
            end
            END: begin
                if (bit_cnt == BITS_FULL) begin
                    finish_good = 1'b1;
                end else if (bit_cnt != '0) begin
                    finish_bad = 1'b1;
                end
                if (ss_fall) begin
                    start_frame = 1'b1;
                    state_next  = SHIFT;
                end else begin
                    state_next  = IDLE;
                end
            end
            default: state_next = WAIT_IDLE;
        endcase
    end

    // Bits past DATA_WIDTH are counted (so the frame is flagged) but never shifted in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (start_frame) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (take_bit) begin
            if (bit_cnt < BITS_FULL) begin
                shift_reg <= {shift_reg[DATA_WIDTH-2:0], mosi_s};
            end
            if (bit_cnt != BITS_OVER) begin
                bit_cnt <= bit_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_error    <= 1'b0;
            dac_voltage <= '0;
            frame_count <= '0;
        end else begin
            rx_valid <= finish_good;
            rx_error <= finish_bad;
            if (finish_good) begin
                rx_data     <= shift_reg;
                dac_voltage <= shift_reg;
                frame_count <= frame_count + CNT_WIDTH'(1);
            end else if (finish_bad) begin
                rx_data <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_spi_dac_word_receiver.sv
// Scoreboard bench: frames are driven on the SPI pins, the expected pulse is queued at
// issue time, and a negedge monitor pops and compares whenever the receiver pulses.
module tb_spi_dac_word_receiver;

    localparam int DW = 8;
    localparam int HALF_SCK = 40;

    typedef struct packed {
        logic          good;
        logic [DW-1:0] data;
        logic [DW-1:0] dac;
        logic [7:0]    count;
    } exp_t;

    logic          clk;
    logic          reset;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_error;
    logic [DW-1:0] dac_voltage;
    logic [7:0]    frame_count;
    logic          busy;

    spi_dac_word_receiver_if spi_bus ();

    spi_dac_word_receiver #(
        .DATA_WIDTH (DW),
        .SYNC_STAGES(2),
        .CNT_WIDTH  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .spi        (spi_bus.slave),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_error   (rx_error),
        .dac_voltage(dac_voltage),
        .frame_count(frame_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   valid_pulses = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [DW-1:0] model_dac = '0;
    int   model_count = 0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Model: a frame of n bits yields a good word for n==DW, an error with the first
    // min(n,DW) bits (right-aligned) otherwise, and nothing for n==0.
    task automatic expect_frame(input logic [15:0] bits, input int nbits);
        exp_t e;
        logic [15:0] word;
        if (nbits == 0) return;
        if (nbits > DW) word = bits >> (nbits - DW);
        else            word = bits & ((16'd1 << nbits) - 16'd1);
        e.good = (nbits == DW);
        e.data = word[DW-1:0];
        if (e.good) begin
            model_dac   = word[DW-1:0];
            model_count = (model_count + 1) % 256;
        end
        e.dac   = model_dac;
        e.count = 8'(model_count);
        exp_q.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        spi_bus.spi_mosi = b;
        #HALF_SCK spi_bus.spi_clk = 1'b1;
        #HALF_SCK spi_bus.spi_clk = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [15:0] bits, input int nbits);
        @(negedge clk);
        expect_frame(bits, nbits);
        spi_bus.spi_ss = 1'b0;
        #HALF_SCK;
        for (int i = nbits - 1; i >= 0; i--) send_bit(bits[i]);
        #HALF_SCK spi_bus.spi_ss = 1'b1;
        #HALF_SCK;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        model_dac   = '0;
        model_count = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_rx_data"}, 32'(rx_data), 32'd0);
        check_output({tag, "_pulses"}, {30'd0, rx_valid, rx_error}, 32'd0);
        check_output({tag, "_dac"}, 32'(dac_voltage), 32'd0);
        check_output({tag, "_count"}, 32'(frame_count), 32'd0);
        check_output({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rx_valid && rx_error) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL both_pulses: got valid=1 error=1, required at most one");
        end else if (rx_valid || rx_error) begin
            if (rx_valid) valid_pulses++;
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL unexpected_pulse: got valid=%0b error=%0b, required no pulse", rx_valid, rx_error);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("pulse_kind_valid", 32'(rx_valid), 32'(mon_e.good));
                check_output("rx_data", 32'(rx_data), 32'(mon_e.data));
                check_output("dac_voltage", 32'(dac_voltage), 32'(mon_e.dac));
                check_output("frame_count", 32'(frame_count), 32'(mon_e.count));
            end
        end
    end

    initial begin
        reset            = 1'b0;
        spi_bus.spi_ss   = 1'b1;
        spi_bus.spi_clk  = 1'b0;
        spi_bus.spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("in_reset");
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check_idle_outputs("after_reset");

        $display("[TB] single frame 0xA5");
        apply_stimulus(16'hA5, 8);
        wait_drain();
        check_output("a5_dac", 32'(dac_voltage), 32'hA5);
        check_output("a5_count", 32'(frame_count), 32'd1);

        $display("[TB] back-to-back frames");
        apply_stimulus(16'h00, 8);
        apply_stimulus(16'hFF, 8);
        apply_stimulus(16'h3C, 8);
        wait_drain();
        check_output("b2b_dac", 32'(dac_voltage), 32'h3C);
        check_output("b2b_count", 32'(frame_count), 32'd4);

        $display("[TB] short and long frames");
        apply_stimulus(16'h0015, 5);
        apply_stimulus({6'd0, 8'hC3, 2'b10}, 10);
        wait_drain();
        check_output("bad_rx_data", 32'(rx_data), 32'hC3);
        check_output("bad_dac_kept", 32'(dac_voltage), 32'h3C);
        check_output("bad_count_kept", 32'(frame_count), 32'd4);

        $display("[TB] ss pulse without spi_clk");
        @(negedge clk);
        check_output("busy_before", 32'(busy), 32'd0);
        spi_bus.spi_ss = 1'b0;
        #50 check_output("busy_during", 32'(busy), 32'd1);
        #50 spi_bus.spi_ss = 1'b1;
        #60 check_output("busy_after", 32'(busy), 32'd0);
        wait_drain();

        $display("[TB] reset mid-frame");
        @(negedge clk);
        spi_bus.spi_ss = 1'b0;
        #HALF_SCK;
        for (int i = 3; i >= 0; i--) send_bit(1'($urandom_range(0, 1)));
        reset       = 1'b0;
        model_dac   = '0;
        model_count = 0;
        #30 check_idle_outputs("mid_reset");
        reset = 1'b1;
        for (int i = 3; i >= 0; i--) send_bit(1'($urandom_range(0, 1)));
        #HALF_SCK spi_bus.spi_ss = 1'b1;
        #HALF_SCK;
        repeat (10) @(negedge clk);
        check_output("post_reset_count", 32'(frame_count), 32'd0);
        apply_stimulus(16'h5A, 8);
        wait_drain();
        check_output("5a_dac", 32'(dac_voltage), 32'h5A);

        $display("[TB] randomized frames");
        for (int f = 0; f < 30; f++) begin
            apply_stimulus(16'($urandom), int'($urandom_range(0, 11)));
        end
        wait_drain();

        $display("[TB] frame counter wrap");
        do_reset();
        repeat (8) @(negedge clk);
        valid_pulses = 0;
        for (int f = 0; f < 256; f++) begin
            apply_stimulus(16'($urandom_range(0, 255)), 8);
        end
        wait_drain();
        check_output("wrap_count", 32'(frame_count), 32'd0);
        check_output("wrap_valid_pulses", 32'(valid_pulses), 32'd256);
        check_output("wrap_dac", 32'(dac_voltage), 32'(model_dac));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
